grid_overlay_gen: RTL and testbench
===================================

// Module: grid_overlay_gen
// PURPOSE
//  Parametrised, pipelined background generator for the VGA scope display: grid lines, axes and
//  axis ticks over a configurable colour scheme, with runtime mode select. Sits between the VGA
//  controller's coordinate outputs and the waveform/colour mixer, replacing the fixed-line grid.
//  Modulo phases are tracked by incremental counters (no dividers).
//  Colour and mode changes are double-buffered so they never tear mid-frame.
// PARAMETERS
//  COORD_W   12    coordinate width
//  H_ACTIVE  1280  active pixels per line; HORZ >= H_ACTIVE is blanked
//  V_ACTIVE  1024  active lines per frame; VERT >= V_ACTIVE is blanked
//  GRID_X    80    horizontal grid-line pitch (pixels)
//  GRID_Y    64    vertical grid-line pitch (lines)
//  TICK_X    16    tick pitch along horizontal axis
//  TICK_Y    8     tick pitch along vertical axis
//  TICK_LEN  4     tick half-length (pixels either side of axis)
//  AXIS_X    640   column of vertical axis;  AXIS_Y 512  row of horizontal axis
// PORTS
//  CLK_VGA          in   1   pixel clock
//  RESETN           in   1   asynchronous, active-low reset
//  PIX_VALID        in   1   coordinate pair valid this cycle
//  VGA_HORZ_COORD   in   12  current column (raster order)
//  VGA_VERT_COORD   in   12  current row
//  MODE             in   2   0 background, 1 grid+axes, 2 grid+axes+ticks, 3 dotted grid+axes+ticks
//  CFG_WR           in   1   write strobe for colour shadow register
//  CFG_SEL          in   2   0 grid, 1 tick, 2 axis, 3 background colour
//  CFG_DATA         in   12  RGB444 {R,G,B}
//  CFG_PENDING      out  1   shadow holds uncommitted writes
//  SYNC_ERR         out  1   sticky: non-raster coordinate step seen
//  GRID_VALID       out  1   PIX_VALID delayed 2 cycles
//  VGA_Red_Grid     out  4   pixel colour, red;  VGA_Green_Grid / VGA_Blue_Grid out 4 likewise
// BEHAVIOUR
//  - Reset: all outputs 0; phase counters 0; active colours grid 0x0D0, tick 0xFFF, axis 0x0F0,
//    bg 0x000; active MODE 2; shadow = active; in_sync=0.
//  - Phase tracking, per PIX_VALID: HORZ==0 -> px_grid=px_tick=0; else each +1 wrapping at
//    GRID_X/TICK_X. At HORZ==0: VERT==0 -> py_*=0 and in_sync=1; else py_* +1 wrapping at GRID_Y/TICK_Y.
//    Invariant: px_grid == HORZ mod GRID_X for the current pixel (likewise the others).
//  - SYNC_ERR set when PIX_VALID and HORZ != 0 and HORZ != prev_HORZ+1; cleared only by reset.
//    No PIX_VALID -> counters hold.
//  - Classification, priority axis > tick > grid > bg, using active MODE:
//    axis: MODE!=0 and (HORZ==AXIS_X or VERT==AXIS_Y);
//    tick: MODE>=2 and ((VERT==AXIS_Y+-TICK_LEN incl. and px_tick==0) or (HORZ within AXIS_X+-TICK_LEN and py_tick==0));
//    grid: MODE!=0 and (px_grid==0 or py_grid==0); MODE 3 keeps only pixels with HORZ[0]^VERT[0]==0.
//    Blanked area -> 0x000. in_sync==0 -> bg colour (grid suppressed until first frame start).
//  - Pipeline: stage1 registers class (2b) + blank; stage2 registers colour. Latency 2, throughput 1/clk.
//  - Config: CFG_WR writes shadow[CFG_SEL], sets CFG_PENDING. Commit (shadow->active, MODE->active)
//    when frame-start pixel (HORZ==0,VERT==0,PIX_VALID) enters stage1; that pixel uses new values.
//    CFG_WR coincident with commit: old shadow committed, new write lands in shadow, PENDING stays 1.
//    MODE is sampled only at commit.
//  - Reset mid-frame: pipeline flushed (GRID_VALID=0), output bg until next frame start.
// STRUCTURE
//  - Package grid_pkg: colour-select enum (GRID/TICK/AXIS/BG), mode enum, default RGB444 constants, class codes.
//  - Sub-module grid_phase_counter (modulo counter, params MOD; inputs sync-clear, advance):
//    four instances (px_grid, px_tick, py_grid, py_tick).
// TESTING
//  1 Reset release, full 1280x1024 frame MODE 2 -> (80,5) grid 0x0D0; (640,300) axis 0x0F0;
//    (656,510) tick 0xFFF; (1300,5) 0x000; output 2 clk after input.
//  2 MODE 3 -> (80,1) grid? no (bit0 differ) bg; (80,2) grid 0x0D0; MODE 0 -> only bg everywhere.
//  3 CFG_WR sel 0 data 0xF00 mid-frame -> rest of frame still 0x0D0, PENDING=1; next frame
//    (0,0) onward grid 0xF00, PENDING=0.
//  4 CFG_WR on the frame-start cycle -> value appears one frame later, PENDING held 1.
//  5 HORZ jump 10->20 -> SYNC_ERR=1 and stays 1; counters resync at next HORZ==0.
//  6 RESETN low at line 300 -> outputs 0 immediately; after release bg only until (0,0), then full grid.

Source files
------------

// File: rtl/grid_pkg.sv
// grid_pkg: shared types and constants for the scope-background generator.
//   cfg_sel_e   - colour shadow register select (CFG_SEL encoding)
//   mode_e      - overlay mode (MODE encoding)
//   pix_class_e - per-pixel classification carried through stage 1
//   default_rgb - reset colour for each colour slot
//   classify    - axis > tick > grid > background priority resolution
package grid_pkg;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        SEL_GRID = 2'd0,
        SEL_TICK = 2'd1,
        SEL_AXIS = 2'd2,
        SEL_BG   = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        MODE_BG     = 2'd0,
        MODE_GRID   = 2'd1,
        MODE_TICKS  = 2'd2,
        MODE_DOTTED = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CLS_BG   = 2'd0,
        CLS_GRID = 2'd1,
        CLS_TICK = 2'd2,
        CLS_AXIS = 2'd3
    } pix_class_e;

    localparam rgb444_t RGB_GRID_DEF = 12'h0D0;
    localparam rgb444_t RGB_TICK_DEF = 12'hFFF;
    localparam rgb444_t RGB_AXIS_DEF = 12'h0F0;
    localparam rgb444_t RGB_BG_DEF   = 12'h000;
    localparam mode_e   MODE_DEF     = MODE_TICKS;

    function automatic rgb444_t default_rgb(input cfg_sel_e sel);
        case (sel)
            SEL_GRID: default_rgb = RGB_GRID_DEF;
            SEL_TICK: default_rgb = RGB_TICK_DEF;
            SEL_AXIS: default_rgb = RGB_AXIS_DEF;
            default:  default_rgb = RGB_BG_DEF;
        endcase
    endfunction

    function automatic pix_class_e classify(input logic is_axis, input logic is_tick,
                                            input logic is_grid);
        if (is_axis)      classify = CLS_AXIS;
        else if (is_tick) classify = CLS_TICK;
        else if (is_grid) classify = CLS_GRID;
        else              classify = CLS_BG;
    endfunction

endpackage

// File: rtl/grid_phase_counter.sv
// grid_phase_counter: modulo-MOD phase tracker replacing a coordinate divider.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - pixel valid; counter holds when low
//   clr_i         - restart phase at 0 for this pixel (wins over adv_i)
//   adv_i         - step phase by one, wrapping at MOD
//   phase_o       - phase of the *current* pixel (combinational, includes this
//                   cycle's clear/advance), so phase_o == coord mod MOD
module grid_phase_counter #(
    parameter int unsigned MOD = 80,
    localparam int unsigned W  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         adv_i,
    output logic [W-1:0] phase_o
);

    logic [W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (en_i) begin
            if (clr_i)
                phase_d = '0;
            else if (adv_i)
                phase_d = (phase_q == W'(MOD - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    assign phase_o = phase_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) phase_q <= '0;
        else         phase_q <= phase_d;
    end

endmodule

// File: rtl/grid_overlay_gen.sv
// grid_overlay_gen: pipelined grid / axis / tick background for the VGA scope.
//   CLK_VGA, RESETN            - pixel clock, asynchronous active-low reset
//   PIX_VALID, VGA_*_COORD     - raster coordinate of the current pixel
//   MODE                       - overlay mode, taken at frame start only
//   CFG_WR, CFG_SEL, CFG_DATA  - colour shadow write port (RGB444)
//   CFG_PENDING                - shadow holds writes not yet committed
//   SYNC_ERR                   - sticky: non-raster horizontal step seen
//   GRID_VALID                 - PIX_VALID delayed by the 2-stage pipeline
//   VGA_{Red,Green,Blue}_Grid  - pixel colour, 2 clocks after the coordinate
module grid_overlay_gen
    import grid_pkg::*;
#(
    parameter int unsigned COORD_W  = 12,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned GRID_X   = 80,
    parameter int unsigned GRID_Y   = 64,
    parameter int unsigned TICK_X   = 16,
    parameter int unsigned TICK_Y   = 8,
    parameter int unsigned TICK_LEN = 4,
    parameter int unsigned AXIS_X   = 640,
    parameter int unsigned AXIS_Y   = 512
) (
    input  logic               CLK_VGA,
    input  logic               RESETN,
    input  logic               PIX_VALID,
    input  logic [COORD_W-1:0] VGA_HORZ_COORD,
    input  logic [COORD_W-1:0] VGA_VERT_COORD,
    input  logic [1:0]         MODE,
    input  logic               CFG_WR,
    input  logic [1:0]         CFG_SEL,
    input  logic [11:0]        CFG_DATA,
    output logic               CFG_PENDING,
    output logic               SYNC_ERR,
    output logic               GRID_VALID,
    output logic [3:0]         VGA_Red_Grid,
    output logic [3:0]         VGA_Green_Grid,
    output logic [3:0]         VGA_Blue_Grid
);

    localparam logic [COORD_W-1:0] H_ACT = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] AX    = COORD_W'(AXIS_X);
    localparam logic [COORD_W-1:0] AY    = COORD_W'(AXIS_Y);
    localparam logic [COORD_W-1:0] AX_LO = COORD_W'(AXIS_X - TICK_LEN);
    localparam logic [COORD_W-1:0] AX_HI = COORD_W'(AXIS_X + TICK_LEN);
    localparam logic [COORD_W-1:0] AY_LO = COORD_W'(AXIS_Y - TICK_LEN);
    localparam logic [COORD_W-1:0] AY_HI = COORD_W'(AXIS_Y + TICK_LEN);

    logic [COORD_W-1:0] horz, vert;
    assign horz = VGA_HORZ_COORD;
    assign vert = VGA_VERT_COORD;

    logic line_start, frame_start;
    assign line_start  = (horz == '0);
    assign frame_start = PIX_VALID && line_start && (vert == '0);

    // ---------------- phase counters ----------------
    logic [$clog2(GRID_X)-1:0] px_grid;
    logic [$clog2(TICK_X)-1:0] px_tick;
    logic [$clog2(GRID_Y)-1:0] py_grid;
    logic [$clog2(TICK_Y)-1:0] py_tick;

    grid_phase_counter #(.MOD(GRID_X)) u_px_grid (
        .clk_i(CLK_VGA), .rst_ni(RESETN), .en_i(PIX_VALID),
        .clr_i(line_start), .adv_i(1'b1), .phase_o(px_grid)
    );
    grid_phase_counter #(.MOD(TICK_X)) u_px_tick (
        .clk_i(CLK_VGA), .rst_ni(RESETN), .en_i(PIX_VALID),
        .clr_i(line_start), .adv_i(1'b1), .phase_o(px_tick)
    );
    grid_phase_counter #(.MOD(GRID_Y)) u_py_grid (
        .clk_i(CLK_VGA), .rst_ni(RESETN), .en_i(PIX_VALID),
        .clr_i(line_start && (vert == '0)), .adv_i(line_start), .phase_o(py_grid)
    );
    grid_phase_counter #(.MOD(TICK_Y)) u_py_tick (
        .clk_i(CLK_VGA), .rst_ni(RESETN), .en_i(PIX_VALID),
        .clr_i(line_start && (vert == '0)), .adv_i(line_start), .phase_o(py_tick)
    );

    // ---------------- configuration / sync state ----------------
    rgb444_t            shadow_q [4];
    rgb444_t            active_q [4];
    mode_e              mode_q;
    logic               pending_q;
    logic               in_sync_q;
    logic               sync_err_q;
    logic [COORD_W-1:0] prev_horz_q;

    always_ff @(posedge CLK_VGA or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < 4; i++) begin
                shadow_q[i] <= default_rgb(cfg_sel_e'(2'(i)));
                active_q[i] <= default_rgb(cfg_sel_e'(2'(i)));
            end
            mode_q      <= MODE_DEF;
            pending_q   <= 1'b0;
            in_sync_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            prev_horz_q <= '0;
        end else begin
            // Commit copies the pre-write shadow; a coincident write lands
            // in the shadow afterwards and keeps PENDING set.
            if (frame_start) begin
                active_q  <= shadow_q;
                mode_q    <= mode_e'(MODE);
                in_sync_q <= 1'b1;
            end
            if (CFG_WR)
                shadow_q[CFG_SEL] <= CFG_DATA;
            pending_q <= CFG_WR || (pending_q && !frame_start);
            if (PIX_VALID) begin
                prev_horz_q <= horz;
                if (!line_start && (horz != prev_horz_q + 1'b1))
                    sync_err_q <= 1'b1;
            end
        end
    end

    // ---------------- classification (stage 0, combinational) ----------------
    // The frame-start pixel already sees the newly committed mode.
    mode_e      mode_cur;
    logic       sync_cur;
    logic       is_axis, is_tick, is_grid, blank;
    pix_class_e cls_d;

    always_comb begin
        mode_cur = frame_start ? mode_e'(MODE) : mode_q;
        sync_cur = in_sync_q || frame_start;
        is_axis  = (mode_cur != MODE_BG) && ((horz == AX) || (vert == AY));
        is_tick  = (mode_cur inside {MODE_TICKS, MODE_DOTTED}) &&
                   (((vert >= AY_LO) && (vert <= AY_HI) && (px_tick == '0)) ||
                    ((horz >= AX_LO) && (horz <= AX_HI) && (py_tick == '0)));
        is_grid  = (mode_cur != MODE_BG) && ((px_grid == '0) || (py_grid == '0)) &&
                   !((mode_cur == MODE_DOTTED) && (horz[0] ^ vert[0]));
        blank    = (horz >= H_ACT) || (vert >= V_ACT);
        cls_d    = sync_cur ? classify(is_axis, is_tick, is_grid) : CLS_BG;
    end

    // ---------------- stage 1: class + blank ----------------
    logic       s1_valid_q, s1_blank_q;
    pix_class_e s1_cls_q;

    always_ff @(posedge CLK_VGA or negedge RESETN) begin
        if (!RESETN) begin
            s1_valid_q <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_cls_q   <= CLS_BG;
        end else begin
            s1_valid_q <= PIX_VALID;
            s1_blank_q <= blank;
            s1_cls_q   <= cls_d;
        end
    end

    // ---------------- stage 2: colour lookup ----------------
    rgb444_t rgb_d, rgb_q;
    logic    valid_q;

    always_comb begin
        rgb_d = '0;
        if (s1_valid_q && !s1_blank_q) begin
            case (s1_cls_q)
                CLS_AXIS: rgb_d = active_q[SEL_AXIS];
                CLS_TICK: rgb_d = active_q[SEL_TICK];
                CLS_GRID: rgb_d = active_q[SEL_GRID];
                default:  rgb_d = active_q[SEL_BG];
            endcase
        end
    end

    always_ff @(posedge CLK_VGA or negedge RESETN) begin
        if (!RESETN) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= s1_valid_q;
        end
    end

    assign {VGA_Red_Grid, VGA_Green_Grid, VGA_Blue_Grid} = rgb_q;
    assign GRID_VALID  = valid_q;
    assign CFG_PENDING = pending_q;
    assign SYNC_ERR    = sync_err_q;

endmodule

// File: tb/tb_grid_overlay_gen.sv
// tb_grid_overlay_gen: directed bench for grid_overlay_gen. Rows are driven
// contiguously from column 0 only as far as the furthest probe on that row,
// so whole frames stay short while phase counters remain raster-correct.
module tb_grid_overlay_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pv;
    logic [11:0] horz, vert;
    logic [1:0]  mode;
    logic        cfg_wr;
    logic [1:0]  cfg_sel;
    logic [11:0] cfg_data;
    logic        cfg_pending, sync_err, gvalid;
    logic [3:0]  red, green, blue;
    logic [11:0] rgb;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    grid_overlay_gen dut (
        .CLK_VGA       (clk),
        .RESETN        (rstn),
        .PIX_VALID     (pv),
        .VGA_HORZ_COORD(horz),
        .VGA_VERT_COORD(vert),
        .MODE          (mode),
        .CFG_WR        (cfg_wr),
        .CFG_SEL       (cfg_sel),
        .CFG_DATA      (cfg_data),
        .CFG_PENDING   (cfg_pending),
        .SYNC_ERR      (sync_err),
        .GRID_VALID    (gvalid),
        .VGA_Red_Grid  (red),
        .VGA_Green_Grid(green),
        .VGA_Blue_Grid (blue)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    // probe table: (x,y) -> expected colour
    string       pr_n [16];
    int          pr_x [16];
    int          pr_y [16];
    logic [11:0] pr_e [16];
    int          pr_cnt;
    int          row_last [0:1025];

    // last driven pixel, whose colour appears after the next clock
    bit h_v;
    int h_x, h_y;

    // mid-frame config write and coordinate jump hooks
    int          wr_x = -1, wr_y = -1;
    logic [1:0]  wr_sel;
    logic [11:0] wr_data;
    int          jmp_y = -1, jmp_from, jmp_to;

    task automatic clear_probes();
        pr_cnt = 0;
        for (int r = 0; r <= 1025; r++) row_last[r] = 0;
    endtask

    task automatic add_probe(input string n, input int x, input int y, input logic [11:0] e);
        pr_n[pr_cnt] = n;
        pr_x[pr_cnt] = x;
        pr_y[pr_cnt] = y;
        pr_e[pr_cnt] = e;
        pr_cnt++;
        if (x > row_last[y]) row_last[y] = x;
    endtask

    task automatic step(input bit v, input int x, input int y);
        pv       = v;
        horz     = x[11:0];
        vert     = y[11:0];
        cfg_wr   = v && (x == wr_x) && (y == wr_y);
        cfg_sel  = wr_sel;
        cfg_data = wr_data;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        if (h_v) begin
            for (int i = 0; i < pr_cnt; i++) begin
                if (pr_x[i] == h_x && pr_y[i] == h_y) begin
                    chk(pr_n[i], rgb, pr_e[i]);
                    chk({pr_n[i], "/valid"}, 12'(gvalid), 12'd1);
                end
            end
        end
        h_v = v;
        h_x = x;
        h_y = y;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int y = first; y <= last; y++) begin
            int x;
            x = 0;
            while (x <= row_last[y]) begin
                step(1'b1, x, y);
                if (y == jmp_y && x == jmp_from) x = jmp_to;
                else x++;
            end
        end
    endtask

    task automatic frame_done();
        step(1'b0, 0, 0);
        clear_probes();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; pv = 1'b0; horz = '0; vert = '0; mode = 2'd2;
        cfg_wr = 1'b0; cfg_sel = '0; cfg_data = '0; wr_sel = '0; wr_data = '0;
        h_v = 1'b0; h_x = 0; h_y = 0;
        clear_probes();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_valid", 12'(gvalid), 12'd0);
        chk("rst_pending", 12'(cfg_pending), 12'd0);
        chk("rst_syncerr", 12'(sync_err), 12'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: default colours, MODE 2
        add_probe("t1_origin", 0, 0, 12'h0D0);
        add_probe("t1_axis_over_grid", 640, 0, 12'h0F0);
        add_probe("t1_grid", 80, 5, 12'h0D0);
        add_probe("t1_bg", 10, 5, 12'h000);
        add_probe("t1_hblank", 1300, 5, 12'h000);
        add_probe("t1_vtick", 636, 8, 12'hFFF);
        add_probe("t1_axis", 640, 300, 12'h0F0);
        add_probe("t1_tick", 656, 510, 12'hFFF);
        add_probe("t1_tick_over_grid", 80, 510, 12'hFFF);
        add_probe("t1_vblank", 0, 1025, 12'h000);
        run_rows(0, 1025);
        frame_done();

        // 2: dotted grid, then background only
        mode = 2'd3;
        add_probe("t2_dot_odd", 80, 1, 12'h000);
        add_probe("t2_axis_solid", 640, 1, 12'h0F0);
        add_probe("t2_dot_even", 80, 2, 12'h0D0);
        add_probe("t2_tick", 656, 510, 12'hFFF);
        run_rows(0, 1023);
        frame_done();

        mode = 2'd0;
        add_probe("t2_m0_grid", 80, 2, 12'h000);
        add_probe("t2_m0_axis", 640, 300, 12'h000);
        add_probe("t2_m0_tick", 656, 510, 12'h000);
        run_rows(0, 1023);
        frame_done();

        // 3: mid-frame colour write commits at the next frame start
        mode = 2'd2;
        wr_x = 40; wr_y = 5; wr_sel = 2'd0; wr_data = 12'hF00;
        add_probe("t3_old_after_wr", 80, 5, 12'h0D0);
        add_probe("t3_old_next_row", 0, 64, 12'h0D0);
        run_rows(0, 1023);
        frame_done();
        wr_x = -1;
        chk("t3_pending_set", 12'(cfg_pending), 12'd1);
        add_probe("t3_new_origin", 0, 0, 12'hF00);
        add_probe("t3_new_grid", 80, 5, 12'hF00);
        run_rows(0, 1023);
        frame_done();
        chk("t3_pending_clr", 12'(cfg_pending), 12'd0);

        // 4: write on the frame-start pixel is deferred one frame
        wr_x = 0; wr_y = 0; wr_sel = 2'd0; wr_data = 12'h00F;
        add_probe("t4_same_frame", 80, 5, 12'hF00);
        run_rows(0, 1023);
        frame_done();
        wr_x = -1;
        chk("t4_pending_held", 12'(cfg_pending), 12'd1);
        add_probe("t4_next_frame", 80, 5, 12'h00F);
        run_rows(0, 1023);
        frame_done();
        chk("t4_pending_clr", 12'(cfg_pending), 12'd0);

        // 5: column jump 10 -> 20 on row 5
        chk("t5_syncerr_before", 12'(sync_err), 12'd0);
        jmp_y = 5; jmp_from = 10; jmp_to = 20;
        add_probe("t5_desync_80", 80, 5, 12'h000);
        add_probe("t5_desync_89", 89, 5, 12'h00F);
        add_probe("t5_resync", 80, 6, 12'h00F);
        run_rows(0, 1023);
        frame_done();
        jmp_y = -1;
        chk("t5_syncerr_set", 12'(sync_err), 12'd1);
        add_probe("t5_normal", 80, 5, 12'h00F);
        run_rows(0, 1023);
        frame_done();
        chk("t5_syncerr_sticky", 12'(sync_err), 12'd1);

        // 6: reset in the middle of line 300
        run_rows(0, 299);
        for (int x = 0; x <= 100; x++) step(1'b1, x, 300);
        #2;
        rstn = 1'b0;
        pv   = 1'b0;
        #1;
        chk("t6_rst_rgb", rgb, 12'h000);
        chk("t6_rst_valid", 12'(gvalid), 12'd0);
        h_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("t6_pending", 12'(cfg_pending), 12'd0);
        chk("t6_syncerr", 12'(sync_err), 12'd0);
        add_probe("t6_nosync_grid", 80, 320, 12'h000);
        add_probe("t6_nosync_axis", 640, 400, 12'h000);
        add_probe("t6_nosync_tick", 656, 510, 12'h000);
        run_rows(301, 1023);
        frame_done();
        add_probe("t6_grid_back", 80, 5, 12'h0D0);
        add_probe("t6_axis_back", 640, 300, 12'h0F0);
        run_rows(0, 1023);
        frame_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
